// File: rtl/vpu_sram_w_port_responder_if.sv
// Host-side write-port bundle for the VPU SRAM write protocol.
// The host drives a beat (req/wid/addr/web/wlast/wdata) and holds it
// until the bank responder returns ack; err flags a protocol violation.
interface vpu_sram_w_port_responder_if #(
  parameter int unsigned WID_W  = 2,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 256
);

  logic              req_i;
  logic [WID_W-1:0]  wid_i;
  logic [ADDR_W-1:0] addr_i;
  logic              web_i;
  logic              wlast_i;
  logic [DATA_W-1:0] wdata_i;
  logic              ack_o;
  logic              err_o;

  // Write-port host (writeback unit) side
  modport master (
    output req_i,
    output wid_i,
    output addr_i,
    output web_i,
    output wlast_i,
    output wdata_i,
    input  ack_o,
    input  err_o
  );

  // Bank responder side
  modport slave (
    input  req_i,
    input  wid_i,
    input  addr_i,
    input  web_i,
    input  wlast_i,
    input  wdata_i,
    output ack_o,
    output err_o
  );

endinterface

// File: rtl/vpu_sram_w_port_responder.sv
// Bank-side responder for the VPU SRAM write port.
// Accepts single and wlast-terminated multi-beat writes, turns each beat
// into one bank write strobe with a one-cycle ack, locks the target bank
// for the life of an open burst and pulses err on protocol violations.
module vpu_sram_w_port_responder #(
  parameter int unsigned SRAM_BANK_CNT       = 4,
  parameter int unsigned SRAM_BANK_CNT_LG2   = 2,
  parameter int unsigned SRAM_BANK_DEPTH_LG2 = 10,
  parameter int unsigned SRAM_DATA_WIDTH     = 256,
  parameter int unsigned MAX_BURST           = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  vpu_sram_w_port_responder_if.slave     host,
  input  logic [SRAM_BANK_CNT-1:0]       bank_busy_i,
  output logic [SRAM_BANK_CNT-1:0]       bank_csb_o,
  output logic                           bank_web_o,
  output logic [SRAM_BANK_DEPTH_LG2-1:0] bank_addr_o,
  output logic [SRAM_DATA_WIDTH-1:0]     bank_wdata_o,
  output logic [SRAM_BANK_CNT-1:0]       bank_lock_o,
  output logic                           idle_o
);

  localparam int unsigned       BCNT_W  = $clog2(MAX_BURST + 1);
  localparam logic [BCNT_W-1:0] MAX_CNT = BCNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_BURST = 2'd2
  } state_t;

  // State and captured beat attributes
  state_t                         r_state;
  logic [SRAM_BANK_CNT_LG2-1:0]   r_wid;
  logic                           r_web;
  logic                           r_wlast;
  logic [BCNT_W-1:0]              r_bcnt;

  // Registered outputs
  logic                           r_ack;
  logic                           r_err;
  logic [SRAM_BANK_CNT-1:0]       r_csb;
  logic                           r_bweb;
  logic [SRAM_BANK_DEPTH_LG2-1:0] r_baddr;
  logic [SRAM_DATA_WIDTH-1:0]     r_bwdata;
  logic [SRAM_BANK_CNT-1:0]       r_lock;
  logic                           r_idle;

  // Next-state values
  state_t                         w_state_nxt;
  logic [SRAM_BANK_CNT_LG2-1:0]   w_wid_nxt;
  logic                           w_web_nxt;
  logic                           w_wlast_nxt;
  logic [BCNT_W-1:0]              w_bcnt_nxt;
  logic                           w_ack_nxt;
  logic                           w_err_nxt;
  logic [SRAM_BANK_CNT-1:0]       w_csb_nxt;
  logic                           w_bweb_nxt;
  logic [SRAM_BANK_DEPTH_LG2-1:0] w_baddr_nxt;
  logic [SRAM_DATA_WIDTH-1:0]     w_bwdata_nxt;
  logic [SRAM_BANK_CNT-1:0]       w_lock_nxt;
  logic                           w_idle_nxt;

  // Beat acceptance and the beat index the accepted beat will carry
  logic                           w_take;
  logic [BCNT_W-1:0]              w_take_cnt;
  logic                           w_burst_end;

  // Write ends the burst when it is last, illegal (web=1) or fills MAX_BURST
  assign w_burst_end = r_wlast || r_web || (r_bcnt == MAX_CNT);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_wid_nxt    = r_wid;
    w_web_nxt    = r_web;
    w_wlast_nxt  = r_wlast;
    w_bcnt_nxt   = r_bcnt;
    w_ack_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    w_csb_nxt    = '1;
    w_bweb_nxt   = 1'b1;
    w_baddr_nxt  = r_baddr;
    w_bwdata_nxt = r_bwdata;
    w_lock_nxt   = r_lock;
    w_take       = 1'b0;
    w_take_cnt   = '0;

    case (r_state)
      S_IDLE: begin
        // New burst may only start when the bank's read port is quiet
        if (host.req_i && !bank_busy_i[host.wid_i]) begin
          w_take     = 1'b1;
          w_take_cnt = BCNT_W'(1);
        end
      end

      S_WRITE: begin
        // Request lines are ignored here; host presents the next beat after ack
        if (w_burst_end) begin
          w_state_nxt = S_IDLE;
          w_lock_nxt  = '0;
          w_bcnt_nxt  = '0;
        end else begin
          w_state_nxt       = S_BURST;
          w_lock_nxt        = '0;
          w_lock_nxt[r_wid] = 1'b1;
        end
      end

      S_BURST: begin
        // Lock owns the bank, so read-port busy is not consulted mid-burst
        if (host.req_i) begin
          if (host.wid_i == r_wid) begin
            w_take     = 1'b1;
            w_take_cnt = (r_bcnt >= MAX_CNT) ? MAX_CNT : r_bcnt + BCNT_W'(1);
          end else begin
            w_err_nxt   = 1'b1;
            w_lock_nxt  = '0;
            w_bcnt_nxt  = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_lock_nxt  = '0;
        w_bcnt_nxt  = '0;
      end
    endcase

    // Accepted beat: capture it and present ack/strobe on the entry edge
    if (w_take) begin
      w_state_nxt = S_WRITE;
      w_wid_nxt   = host.wid_i;
      w_web_nxt   = host.web_i;
      w_wlast_nxt = host.wlast_i;
      w_bcnt_nxt  = w_take_cnt;
      w_ack_nxt   = 1'b1;
      w_err_nxt   = host.web_i || ((w_take_cnt == MAX_CNT) && !host.wlast_i);
      if (!host.web_i) begin
        w_csb_nxt[host.wid_i] = 1'b0;
        w_bweb_nxt            = 1'b0;
        w_baddr_nxt           = host.addr_i;
        w_bwdata_nxt          = host.wdata_i;
      end
    end

    w_idle_nxt = (w_state_nxt == S_IDLE) && (w_lock_nxt == '0);
  end

  // State, capture and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_wid    <= '0;
      r_web    <= 1'b0;
      r_wlast  <= 1'b0;
      r_bcnt   <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_csb    <= '1;
      r_bweb   <= 1'b1;
      r_baddr  <= '0;
      r_bwdata <= '0;
      r_lock   <= '0;
      r_idle   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_wid    <= w_wid_nxt;
      r_web    <= w_web_nxt;
      r_wlast  <= w_wlast_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
      r_csb    <= w_csb_nxt;
      r_bweb   <= w_bweb_nxt;
      r_baddr  <= w_baddr_nxt;
      r_bwdata <= w_bwdata_nxt;
      r_lock   <= w_lock_nxt;
      r_idle   <= w_idle_nxt;
    end
  end

  assign host.ack_o   = r_ack;
  assign host.err_o   = r_err;
  assign bank_csb_o   = r_csb;
  assign bank_web_o   = r_bweb;
  assign bank_addr_o  = r_baddr;
  assign bank_wdata_o = r_bwdata;
  assign bank_lock_o  = r_lock;
  assign idle_o       = r_idle;

endmodule

// File: tb/tb_vpu_sram_w_port_responder.sv
// Self-checking bench for vpu_sram_w_port_responder: directed scenarios
// plus randomized bursts checked against a beat-level expectation model.
module tb_vpu_sram_w_port_responder;

  localparam int unsigned NB   = 4;
  localparam int unsigned WW   = 2;
  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 256;
  localparam int unsigned MAXB = 8;

  logic          clk;
  logic          rst;
  logic [NB-1:0] bank_busy;
  logic [NB-1:0] bank_csb;
  logic          bank_web;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wdata;
  logic [NB-1:0] bank_lock;
  logic          idle;

  int checks;
  int errors;

  vpu_sram_w_port_responder_if #(.WID_W(WW), .ADDR_W(AW), .DATA_W(DW)) host_if ();

  vpu_sram_w_port_responder #(
    .SRAM_BANK_CNT(NB), .SRAM_BANK_CNT_LG2(WW), .SRAM_BANK_DEPTH_LG2(AW),
    .SRAM_DATA_WIDTH(DW), .MAX_BURST(MAXB)
  ) u_dut (
    .clk(clk), .rst(rst), .host(host_if), .bank_busy_i(bank_busy),
    .bank_csb_o(bank_csb), .bank_web_o(bank_web), .bank_addr_o(bank_addr),
    .bank_wdata_o(bank_wdata), .bank_lock_o(bank_lock), .idle_o(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [NB-1:0] onehot(input logic [WW-1:0] w);
    return NB'(1) << w;
  endfunction

  task automatic drive_idle();
    host_if.req_i   = 1'b0;
    host_if.wid_i   = '0;
    host_if.addr_i  = '0;
    host_if.web_i   = 1'b0;
    host_if.wlast_i = 1'b0;
    host_if.wdata_i = '0;
  endtask

  task automatic present(input logic [WW-1:0] w, input logic [AW-1:0] a,
                         input logic we, input logic wl, input logic [DW-1:0] d);
    host_if.req_i   = 1'b1;
    host_if.wid_i   = w;
    host_if.addr_i  = a;
    host_if.web_i   = we;
    host_if.wlast_i = wl;
    host_if.wdata_i = d;
  endtask

  // Waits (bounded) for ack; lat counts negedges from presentation to ack
  task automatic wait_ack(input bit rnd_busy, output int lat, output bit got);
    got = 1'b0;
    lat = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (rnd_busy) bank_busy = NB'($urandom);
      if (host_if.ack_o === 1'b1) begin
        got = 1'b1;
        lat = c;
        break;
      end
    end
  endtask

  task automatic settle();
    drive_idle();
    bank_busy = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bank_busy = '0;
    present(2'd1, 10'h3FF, 1'b0, 1'b1, rand_data());
    repeat (3) @(negedge clk);
    checks++; if (host_if.ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", host_if.ack_o); end
    checks++; if (host_if.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", host_if.err_o); end
    checks++; if (bank_csb !== 4'hF) begin errors++; $display("FAIL reset_csb got %b exp 1111", bank_csb); end
    checks++; if (bank_web !== 1'b1) begin errors++; $display("FAIL reset_web got %b exp 1", bank_web); end
    checks++; if (bank_addr !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", bank_addr); end
    checks++; if (bank_wdata !== '0) begin errors++; $display("FAIL reset_wdata got %h exp 0", bank_wdata); end
    checks++; if (bank_lock !== 4'h0) begin errors++; $display("FAIL reset_lock got %b exp 0000", bank_lock); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle_after got %b exp 1", idle); end
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = {32{8'hA5}};
    present(2'd2, 10'h055, 1'b0, 1'b1, d);
    @(negedge clk);
    checks++; if (host_if.ack_o !== 1'b1) begin errors++; $display("FAIL single_ack got %b exp 1", host_if.ack_o); end
    checks++; if (bank_csb !== 4'b1011) begin errors++; $display("FAIL single_csb got %b exp 1011", bank_csb); end
    checks++; if (bank_web !== 1'b0) begin errors++; $display("FAIL single_web got %b exp 0", bank_web); end
    checks++; if (bank_addr !== 10'h055) begin errors++; $display("FAIL single_addr got %h exp 055", bank_addr); end
    checks++; if (bank_wdata !== d) begin errors++; $display("FAIL single_wdata got %h exp %h", bank_wdata, d); end
    checks++; if (host_if.err_o !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", host_if.err_o); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b exp 0", idle); end
    drive_idle();
    @(negedge clk);
    checks++; if (host_if.ack_o !== 1'b0) begin errors++; $display("FAIL single_ack_drop got %b exp 0", host_if.ack_o); end
    checks++; if (bank_csb !== 4'hF) begin errors++; $display("FAIL single_csb_drop got %b exp 1111", bank_csb); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got %b exp 1", idle); end
    settle();
  endtask

  task automatic test_busy_stall();
    bank_busy = 4'b0010;
    present(2'd1, 10'h1A0, 1'b0, 1'b1, rand_data());
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (host_if.ack_o !== 1'b0) begin errors++; $display("FAIL busy_noack cyc %0d got %b exp 0", c, host_if.ack_o); end
      checks++; if (bank_csb !== 4'hF) begin errors++; $display("FAIL busy_csb cyc %0d got %b exp 1111", c, bank_csb); end
    end
    bank_busy = '0;
    @(negedge clk);
    checks++; if (host_if.ack_o !== 1'b1) begin errors++; $display("FAIL busy_ack got %b exp 1", host_if.ack_o); end
    checks++; if (bank_csb !== 4'b1101) begin errors++; $display("FAIL busy_csb_ack got %b exp 1101", bank_csb); end
    settle();
  endtask

  task automatic test_burst4();
    logic [DW-1:0] d;
    for (int b = 0; b < 4; b++) begin
      d = rand_data();
      present(2'd0, AW'(32'h10 + 32'(b)), 1'b0, (b == 3), d);
      if (b > 0) begin
        @(negedge clk);
        checks++; if (host_if.ack_o !== 1'b0) begin errors++; $display("FAIL burst_gap beat %0d got %b exp 0", b, host_if.ack_o); end
        checks++; if (bank_lock !== 4'b0001) begin errors++; $display("FAIL burst_lock_gap beat %0d got %b exp 0001", b, bank_lock); end
      end
      @(negedge clk);
      checks++; if (host_if.ack_o !== 1'b1) begin errors++; $display("FAIL burst_ack beat %0d got %b exp 1", b, host_if.ack_o); end
      checks++; if (bank_csb !== 4'b1110) begin errors++; $display("FAIL burst_csb beat %0d got %b exp 1110", b, bank_csb); end
      checks++; if (bank_addr !== AW'(32'h10 + 32'(b))) begin errors++; $display("FAIL burst_addr beat %0d got %h exp %h", b, bank_addr, 32'h10 + 32'(b)); end
      checks++; if (bank_wdata !== d) begin errors++; $display("FAIL burst_wdata beat %0d got %h exp %h", b, bank_wdata, d); end
      checks++; if (bank_lock !== ((b == 0) ? 4'b0000 : 4'b0001)) begin errors++; $display("FAIL burst_lock_ack beat %0d got %b", b, bank_lock); end
      if (b == 0) bank_busy = 4'b0001;
    end
    drive_idle();
    @(negedge clk);
    checks++; if (bank_lock !== 4'b0000) begin errors++; $display("FAIL burst_lock_end got %b exp 0000", bank_lock); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL burst_idle_end got %b exp 1", idle); end
    settle();
  endtask

  task automatic test_wrong_bank();
    present(2'd0, 10'h020, 1'b0, 1'b0, rand_data());
    @(negedge clk);
    checks++; if (host_if.ack_o !== 1'b1) begin errors++; $display("FAIL wrong_ack1 got %b exp 1", host_if.ack_o); end
    present(2'd3, 10'h030, 1'b0, 1'b1, rand_data());
    @(negedge clk);
    checks++; if (bank_lock !== 4'b0001) begin errors++; $display("FAIL wrong_lock got %b exp 0001", bank_lock); end
    @(negedge clk);
    checks++; if (host_if.err_o !== 1'b1) begin errors++; $display("FAIL wrong_err got %b exp 1", host_if.err_o); end
    checks++; if (host_if.ack_o !== 1'b0) begin errors++; $display("FAIL wrong_noack got %b exp 0", host_if.ack_o); end
    checks++; if (bank_lock !== 4'b0000) begin errors++; $display("FAIL wrong_unlock got %b exp 0000", bank_lock); end
    @(negedge clk);
    checks++; if (host_if.ack_o !== 1'b1) begin errors++; $display("FAIL wrong_reaccept got %b exp 1", host_if.ack_o); end
    checks++; if (bank_csb !== 4'b0111) begin errors++; $display("FAIL wrong_csb got %b exp 0111", bank_csb); end
    checks++; if (host_if.err_o !== 1'b0) begin errors++; $display("FAIL wrong_err_clr got %b exp 0", host_if.err_o); end
    settle();
  endtask

  task automatic test_web_err();
    present(WW'($urandom_range(0, 3)), 10'h111, 1'b1, 1'b0, rand_data());
    @(negedge clk);
    checks++; if (host_if.ack_o !== 1'b1) begin errors++; $display("FAIL web_ack got %b exp 1", host_if.ack_o); end
    checks++; if (host_if.err_o !== 1'b1) begin errors++; $display("FAIL web_err got %b exp 1", host_if.err_o); end
    checks++; if (bank_csb !== 4'hF) begin errors++; $display("FAIL web_csb got %b exp 1111", bank_csb); end
    drive_idle();
    @(negedge clk);
    checks++; if (bank_lock !== 4'h0) begin errors++; $display("FAIL web_lock got %b exp 0000", bank_lock); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL web_idle got %b exp 1", idle); end
    settle();
  endtask

  task automatic test_overflow();
    logic [WW-1:0] w;
    logic [DW-1:0] d;
    int lat;
    int p;
    bit got;
    w = WW'($urandom_range(0, 3));
    for (int i = 1; i <= 10; i++) begin
      d = rand_data();
      present(w, AW'(i), 1'b0, (i == 10), d);
      wait_ack(1'b0, lat, got);
      checks++;
      if (!got) begin
        errors++; $display("FAIL ovf_timeout beat %0d", i);
      end else begin
        p = (i <= int'(MAXB)) ? i : i - int'(MAXB);
        if (host_if.err_o !== (i == int'(MAXB))) begin errors++; $display("FAIL ovf_err beat %0d got %b", i, host_if.err_o); end
        checks++; if (lat != ((i == 1) ? 1 : 2)) begin errors++; $display("FAIL ovf_lat beat %0d got %0d", i, lat); end
        checks++; if (bank_csb !== ~onehot(w)) begin errors++; $display("FAIL ovf_csb beat %0d got %b", i, bank_csb); end
        checks++; if (bank_lock !== ((p > 1) ? onehot(w) : '0)) begin errors++; $display("FAIL ovf_lock beat %0d got %b", i, bank_lock); end
        checks++; if (bank_wdata !== d) begin errors++; $display("FAIL ovf_wdata beat %0d got %h exp %h", i, bank_wdata, d); end
      end
    end
    drive_idle();
    @(negedge clk);
    checks++; if (bank_lock !== 4'h0) begin errors++; $display("FAIL ovf_lock_end got %b exp 0000", bank_lock); end
    settle();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit got;
    present(2'd1, 10'h0AA, 1'b0, 1'b0, rand_data());
    wait_ack(1'b0, lat, got);
    checks++; if (!got) begin errors++; $display("FAIL rstmid_ack1 timeout"); end
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    checks++; if (host_if.ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_ack got %b exp 0", host_if.ack_o); end
    checks++; if (bank_lock !== 4'h0) begin errors++; $display("FAIL rstmid_lock got %b exp 0000", bank_lock); end
    checks++; if (bank_csb !== 4'hF) begin errors++; $display("FAIL rstmid_csb got %b exp 1111", bank_csb); end
    checks++; if (bank_addr !== '0) begin errors++; $display("FAIL rstmid_addr got %h exp 0", bank_addr); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle got %b exp 1", idle); end
    rst = 1'b0;
    @(negedge clk);
    // Reset while a locked burst has its next beat pending
    present(2'd2, 10'h0BB, 1'b0, 1'b0, rand_data());
    wait_ack(1'b0, lat, got);
    checks++; if (!got) begin errors++; $display("FAIL rstmid_ack2 timeout"); end
    present(2'd2, 10'h0BC, 1'b0, 1'b1, rand_data());
    @(negedge clk);
    checks++; if (bank_lock !== 4'b0100) begin errors++; $display("FAIL rstmid_lock2 got %b exp 0100", bank_lock); end
    rst = 1'b1;
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    checks++; if (host_if.ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_drop got %b exp 0", host_if.ack_o); end
    checks++; if (bank_lock !== 4'h0) begin errors++; $display("FAIL rstmid_lock3 got %b exp 0000", bank_lock); end
    checks++; if (bank_wdata !== '0) begin errors++; $display("FAIL rstmid_wdata got %h exp 0", bank_wdata); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (host_if.ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_late_ack cyc %0d got %b", c, host_if.ack_o); end
    end
    settle();
  endtask

  // Random bursts: every beat acked; web=0 beats write exactly their payload
  task automatic test_random();
    logic [WW-1:0] w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          we;
    logic          wl;
    int            len;
    int            lat;
    bit            got;
    for (int n = 0; n < 60; n++) begin
      w   = WW'($urandom_range(0, NB - 1));
      len = $urandom_range(1, MAXB);
      for (int p = 1; p <= len; p++) begin
        a  = AW'($urandom);
        d  = rand_data();
        we = ($urandom_range(0, 9) == 0);
        wl = (p == len) || we;
        present(w, a, we, wl, d);
        wait_ack(1'b1, lat, got);
        checks++;
        if (!got) begin
          errors++; $display("FAIL rnd_timeout burst %0d beat %0d", n, p);
          break;
        end
        if (host_if.err_o !== we) begin errors++; $display("FAIL rnd_err burst %0d beat %0d got %b exp %b", n, p, host_if.err_o, we); end
        checks++; if (bank_csb !== (we ? 4'hF : ~onehot(w))) begin errors++; $display("FAIL rnd_csb burst %0d beat %0d got %b", n, p, bank_csb); end
        checks++; if (bank_lock !== ((p > 1) ? onehot(w) : '0)) begin errors++; $display("FAIL rnd_lock burst %0d beat %0d got %b", n, p, bank_lock); end
        if (p > 1) begin
          checks++; if (lat != 2) begin errors++; $display("FAIL rnd_lat burst %0d beat %0d got %0d exp 2", n, p, lat); end
        end
        if (!we) begin
          checks++; if (bank_web !== 1'b0) begin errors++; $display("FAIL rnd_web burst %0d beat %0d got %b", n, p, bank_web); end
          checks++; if (bank_addr !== a) begin errors++; $display("FAIL rnd_addr burst %0d beat %0d got %h exp %h", n, p, bank_addr, a); end
          checks++; if (bank_wdata !== d) begin errors++; $display("FAIL rnd_wdata burst %0d beat %0d got %h exp %h", n, p, bank_wdata, d); end
        end
        if (we) break;
      end
      if (($urandom_range(0, 3) == 0)) begin
        drive_idle();
        @(negedge clk);
      end
    end
    settle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bank_busy = '0;
    drive_idle();
    test_reset();
    test_single();
    test_busy_stall();
    test_burst4();
    test_wrong_bank();
    test_web_err();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vpu_sram_w_port_responder.md
Name: vpu_sram_w_port_responder

Overview:
- Bank-side responder for the VPU SRAM write-port protocol (req/wid/addr/web/wlast/wdata in, ack out).
- Sits between write-port hosts (writeback unit) and the SRAM bank array.
- Accepts single-beat and multi-beat (wlast-terminated) writes, converts each beat into one bank write strobe, and returns a one-cycle ack.
- Locks the target bank against reads for the duration of a burst and flags protocol violations.

Parameters:
SRAM_BANK_CNT, 4, number of SRAM banks
SRAM_BANK_CNT_LG2, 2, log2(SRAM_BANK_CNT), width of wid
SRAM_BANK_DEPTH_LG2, 10, bank address width
SRAM_DATA_WIDTH, 256, beat data width
MAX_BURST, 8, maximum beats per burst; BCNT_W = $clog2(MAX_BURST+1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req_i  in  1  host request; held with payload until ack
wid_i  in  SRAM_BANK_CNT_LG2  target bank id
addr_i  in  SRAM_BANK_DEPTH_LG2  bank word address
web_i  in  1  write enable, active-low; 1 = illegal on write port
wlast_i  in  1  last beat of burst
wdata_i  in  SRAM_DATA_WIDTH  beat data
ack_o  out  1  one-cycle beat acknowledge
err_o  out  1  one-cycle protocol-error pulse
bank_busy_i  in  SRAM_BANK_CNT  per-bank read-port busy; blocks burst start
bank_csb_o  out  SRAM_BANK_CNT  per-bank chip select, active-low
bank_web_o  out  1  bank write enable, active-low
bank_addr_o  out  SRAM_BANK_DEPTH_LG2  bank address
bank_wdata_o  out  SRAM_DATA_WIDTH  bank write data
bank_lock_o  out  SRAM_BANK_CNT  one-hot lock of bank owned by an open burst
idle_o  out  1  high in S_IDLE with no lock

Behaviour:
- Reset, effective next edge, any state: state=S_IDLE; ack_o=0; err_o=0; bank_csb_o=all 1; bank_web_o=1; bank_addr_o=0; bank_wdata_o=0; bank_lock_o=0; beat counter=0; idle_o=1. A beat captured but not yet acked is dropped and never acked.
- All outputs are registered.
- S_IDLE:
  - Condition: req_i && !bank_busy_i[wid_i].
  - Action: capture wid/addr/web/wlast/wdata, beat counter=1, go to S_WRITE.
  - If req_i && busy: remain in S_IDLE, no ack. Re-evaluate every cycle.
- S_WRITE (one cycle; outputs visible this cycle, set on entry edge):
  - ack_o=1.
  - If captured web=0: bank_csb_o[wid]=0, bank_web_o=0, bank_addr_o/bank_wdata_o = captured values.
  - If captured web=1: no bank strobe (csb all 1), err_o=1, burst terminated (treated as last).
  - Exit: if last, or beat counter==MAX_BURST with wlast=0 (err_o=1 on the overflow case), go to S_IDLE and clear lock. Otherwise go to S_BURST with bank_lock_o[wid]=1.
- Ack latency: ack_o is high exactly 1 cycle after the acceptance edge. The host drops req or presents the next beat in the cycle after ack. The responder ignores req_i during S_WRITE. Maximum throughput is 1 beat per 2 cycles.
- S_BURST (lock held):
  - req_i && wid_i==locked wid: capture, beat counter+1, go to S_WRITE. bank_busy_i is not checked because the lock owns the bank.
  - req_i && wid_i!=locked wid: err_o=1 next cycle, clear lock, go to S_IDLE. That beat is not accepted; it is re-evaluated as a new burst from S_IDLE.
  - !req_i: hold lock indefinitely, no timeout.
- bank_csb_o is low for at most one bank, for one cycle per accepted web=0 beat.
- idle_o = (state==S_IDLE) && bank_lock_o==0.
- Beat counter saturates at MAX_BURST and never wraps.

Test Plan:
- Single beat, bank 2: req=1, wid=2, addr=0x055, web=0, wlast=1, wdata=0xA5..A5 at T0 -> at T1 ack_o=1, bank_csb_o=4'b1011, bank_web_o=0, bank_addr_o=0x055, bank_wdata_o=0xA5..A5; at T2 state S_IDLE, idle_o=1.
- Busy stall: bank_busy_i=4'b0010, single beat to wid=1 -> no ack while busy. Busy drops at T5 -> accept at T5, ack_o=1 at T6.
- Four-beat burst, wid=0, addrs 0x10..0x13, wlast only on beat 4:
  - 4 ack pulses spaced 2 cycles apart.
  - bank_lock_o=4'b0001 from after beat 1 until beat 4 is acked.
  - bank_busy_i[0]=1 raised mid-burst causes no stall.
- Wrong bank mid-burst: after beat 1 to wid=0, the next req uses wid=3 -> err_o pulse, lock cleared, no ack for that beat. The wid=3 beat is then accepted from S_IDLE and acked.
- web=1 request and overflow:
  - web=1 beat -> ack_o=1, err_o=1, bank_csb_o=4'b1111.
  - 9 beats with wlast=0 and MAX_BURST=8 -> beat 8 is written, acked and err_o=1; beat 9 starts a new burst.
- Reset mid-operation: assert rst in the cycle after acceptance -> no ack, all outputs at reset values next edge, bank_lock_o=0.
